// File: rtl/display_scan_ctrl_if.sv
// Host-side and display-side signals of the four-digit seven-segment scan controller.
interface display_scan_ctrl_if;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_ack;
    logic       pending;
    logic [1:0] digit;
    logic       frame_tick;
    logic [3:0] anode;
    logic [7:0] cathode;

    modport master (
        output enable, wr_en, wr_addr, wr_data, commit,
        input  commit_ack, pending, digit, frame_tick, anode, cathode
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data, commit,
        output commit_ack, pending, digit, frame_tick, anode, cathode
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with a double-buffered segment set.
// The active set swaps only at a frame boundary (or while idle) so no digit ever shows a torn update.
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned   CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [1:0]      digit_r, digit_nxt_s;
    logic            pending_r, pending_nxt_s;
    logic            tick_nxt_s, ack_nxt_s;
    logic            frame_tick_r, commit_ack_r;
    logic [3:0][7:0] shadow_r;
    logic [3:0][7:0] active_r;
    logic [3:0]      anode_r;
    logic [7:0]      cathode_r;

    // Next state, counters and commit bookkeeping
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        digit_nxt_s = digit_r;
        if (!bus.enable) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
            digit_nxt_s = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_BLANK;
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) state_nxt_s = ST_DRIVE;
                    else                     state_nxt_s = ST_BLANK;
                end
                ST_DRIVE: begin
                    if (cnt_r == CNT_LAST) state_nxt_s = ST_BLANK;
                    else                   state_nxt_s = ST_DRIVE;
                end
                default:  state_nxt_s = ST_IDLE;
            endcase
            // The slot counter stays parked at zero for the single idle cycle after enable rises
            if (state_r == ST_IDLE) begin
                cnt_nxt_s = cnt_r;
            end else if (cnt_r == CNT_LAST) begin
                cnt_nxt_s   = '0;
                digit_nxt_s = digit_r + 2'd1;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end
        // Tick and ack are registered from next-cycle values, so they line up with the counters
        pending_nxt_s = commit_ack_r ? 1'b0 : (pending_r | bus.commit);
        tick_nxt_s    = (cnt_nxt_s == CNT_LAST) && (digit_nxt_s == 2'd3);
        ack_nxt_s     = pending_nxt_s && (tick_nxt_s || (state_nxt_s == ST_IDLE));
    end

    // Scan state, counters and commit handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            digit_r      <= 2'd0;
            pending_r    <= 1'b0;
            frame_tick_r <= 1'b0;
            commit_ack_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            digit_r      <= digit_nxt_s;
            pending_r    <= pending_nxt_s;
            frame_tick_r <= tick_nxt_s;
            commit_ack_r <= ack_nxt_s;
        end
    end

    // Shadow writes are always accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (bus.wr_en) begin
            shadow_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active set takes the pre-write shadow in the ack cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= '0;
        end else if (commit_ack_r) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Display drive; enable low darkens the digits on the very next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_r   <= 4'hF;
            cathode_r <= 8'hFF;
        end else if (!bus.enable || (state_r != ST_DRIVE)) begin
            anode_r   <= 4'hF;
            cathode_r <= 8'hFF;
        end else begin
            anode_r   <= ~(4'b0001 << digit_r);
            cathode_r <= ~active_r[digit_r];
        end
    end

    assign bus.commit_ack = commit_ack_r;
    assign bus.pending    = pending_r;
    assign bus.digit      = digit_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.anode      = anode_r;
    assign bus.cathode    = cathode_r;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model compared every cycle,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_display_scan_ctrl;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_on = 1'b0;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: running flag, position within the 4*P-cycle frame, shadow/active copies
    bit         m_run  = 1'b0;
    int         m_pos  = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_act [4] = '{default: 8'h00};
    logic [7:0] m_sh  [4] = '{default: 8'h00};
    logic [3:0] m_anode = 4'hF;
    logic [7:0] m_cath  = 8'hFF;

    function automatic bit m_tick();
        return m_run && (m_pos == FRAME - 1);
    endfunction

    function automatic bit m_ack();
        return m_pend && (m_tick() || !m_run);
    endfunction

    // Reference model update on each clock edge (async reset clears everything)
    always @(posedge clk or negedge rst_n) begin : model_p
        int dg;
        bit drive;
        bit ack;
        if (!rst_n) begin
            m_run = 1'b0; m_pos = 0; m_pend = 1'b0;
            m_act = '{default: 8'h00}; m_sh = '{default: 8'h00};
            m_anode = 4'hF; m_cath = 8'hFF;
        end else begin
            dg    = (m_pos / P) % 4;
            drive = m_run && ((m_pos % P) >= B);
            ack   = m_ack();
            if (!bus.enable || !drive) begin
                m_anode = 4'hF; m_cath = 8'hFF;
            end else begin
                m_anode = ~(4'b0001 << dg); m_cath = ~m_act[dg];
            end
            if (ack) begin
                m_act = m_sh; m_pend = 1'b0;
            end else if (bus.commit) begin
                m_pend = 1'b1;
            end
            if (bus.wr_en) m_sh[bus.wr_addr] = bus.wr_data;
            if (!bus.enable) begin
                m_run = 1'b0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
        end
    end

    // Every DUT output against the model, once per cycle
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("anode",      bus.anode,      m_anode);
            chk("cathode",    bus.cathode,    m_cath);
            chk("digit",      bus.digit,      (m_pos / P) % 4);
            chk("frame_tick", bus.frame_tick, m_tick());
            chk("pending",    bus.pending,    m_pend);
            chk("commit_ack", bus.commit_ack, m_ack());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    task automatic wait_lit(input logic [1:0] dg, input logic [3:0] an, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (bus.digit == dg && bus.anode == an) found = 1'b1;
        end
        chk(name, found, 1'b1);
    endtask

    logic [3:0] an [40];
    logic [1:0] dg [40];
    logic [7:0] ca [40];
    bit         tk [40];

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            an[i] = bus.anode; dg[i] = bus.digit; ca[i] = bus.cathode; tk[i] = bus.frame_tick;
        end
    endtask

    initial begin : stim_p
        int  tick_at;
        int  acks;
        int  at;
        bit  found;
        bit  seen99;
        bit  seena4;
        bit  en_state;

        bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0;
        bus.wr_data = 8'h00; bus.commit = 1'b0;
        #2 rst_n = 1'b0;
        cmp_on = 1'b1;
        #1;
        chk("reset anode",   bus.anode,   4'hF);
        chk("reset cathode", bus.cathode, 8'hFF);
        chk("reset pending", bus.pending, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Scan pattern after enable
        step();
        bus.enable = 1'b1;
        sample(40);
        chk("t1 blank before first drive", an[3],  4'hF);
        chk("t1 digit0 first lit",         an[4],  4'hE);
        chk("t1 digit0 last lit",          an[9],  4'hE);
        chk("t1 gap before digit1",        an[10], 4'hF);
        chk("t1 digit1",                   an[12], 4'hD);
        chk("t1 digit2",                   an[20], 4'hB);
        chk("t1 digit3",                   an[28], 4'h7);
        chk("t1 wrap to digit0",           an[36], 4'hE);
        tick_at = -1;
        for (int i = 0; i < 40; i++) if (tk[i] && tick_at < 0) tick_at = i;
        chk("t1 first frame_tick index", tick_at, 32);

        // Double-buffered commit
        step();
        write(2'd0, 8'h3F); write(2'd1, 8'h06); write(2'd2, 8'h5B); write(2'd3, 8'h4F);
        wait_lit(2'd1, 4'hD, "t2 reach slot1");
        pulse_commit();
        chk("t2 pending after commit", bus.pending, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            @(negedge clk);
            if (bus.commit_ack) begin
                found = 1'b1;
                chk("t2 ack with frame_tick", bus.frame_tick, 1'b1);
            end
        end
        chk("t2 ack seen", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus.anode == 4'hE) begin
                found = 1'b1;
                chk("t2 digit0 new pattern", bus.cathode, 8'hC0);
            end
        end
        chk("t2 digit0 lit", found, 1'b1);

        // Uncommitted shadow write stays invisible
        step();
        write(2'd2, 8'h66);
        seen99 = 1'b0; seena4 = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.cathode == 8'h99) seen99 = 1'b1;
            if (bus.cathode == 8'hA4) seena4 = 1'b1;
        end
        chk("t3 uncommitted never shown", seen99, 1'b0);
        chk("t3 old digit2 shown",        seena4, 1'b1);

        // Commit coinciding with frame_tick waits a full frame; merged second commit
        found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            step();
            if (bus.frame_tick) found = 1'b1;
        end
        chk("t4 frame_tick found", found, 1'b1);
        bus.commit = 1'b1;
        acks = 0; at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.commit_ack) begin
                acks++;
                if (at < 0) at = i;
            end
            step();
            bus.commit = (i == 4);
        end
        chk("t4 single ack", acks, 1);
        chk("t4 ack one frame later", at, 32);

        // Enable low with a pending commit
        wait_lit(2'd1, 4'hD, "t5 reach slot1");
        pulse_commit();
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5 dark anode",   bus.anode,      4'hF);
        chk("t5 dark cathode", bus.cathode,    8'hFF);
        chk("t5 idle ack",     bus.commit_ack, 1'b1);
        step(); step(); step();
        bus.enable = 1'b1;
        sample(5);
        chk("t5 restart blank", an[3], 4'hF);
        chk("t5 restart lit",   an[4], 4'hE);
        chk("t5 restart digit", dg[4], 2'd0);

        // Asynchronous reset in a digit-2 drive slot
        write(2'd1, 8'h77);
        wait_lit(2'd2, 4'hB, "t6 reach slot2");
        pulse_commit();
        chk("t6 pending before reset", bus.pending, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6 async anode",   bus.anode,   4'hF);
        chk("t6 async cathode", bus.cathode, 8'hFF);
        chk("t6 async pending", bus.pending, 1'b0);
        chk("t6 async digit",   bus.digit,   2'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        sample(5);
        chk("t6 restart lit",     an[4], 4'hE);
        chk("t6 restart digit",   dg[4], 2'd0);
        chk("t6 cleared cathode", ca[4], 8'hFF);

        // Randomized traffic with enable in bursts
        en_state = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en_state) en_state = ($urandom_range(0, 199) != 0);
            else          en_state = ($urandom_range(0, 3) == 0);
            bus.enable  = en_state;
            bus.wr_en   = ($urandom_range(0, 9) < 3);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom);
            bus.commit  = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.wr_en = 1'b0; bus.commit = 1'b0;
        repeat (4) step();
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
